// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve block: funct3 branch codes and FSM states.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage to branch resolve bus. Statistics counters exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic [2:0]      funct3;
    logic            BrEq;
    logic            BrLT;
    logic [XLEN-1:0] target;
    logic            stall;

    logic            BrUn;
    logic            PCSel;
    logic [XLEN-1:0] pc_target;
    logic            flush_if;
    logic            flush_id;
    logic            illegal_br;

`ifdef BRANCH_STATS_EN
    logic [31:0]     br_total_cnt;
    logic [31:0]     br_taken_cnt;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, funct3, BrEq, BrLT, target, stall,
        input  BrUn, PCSel, pc_target, flush_if, flush_id, illegal_br,
        input  br_total_cnt, br_taken_cnt
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, funct3, BrEq, BrLT, target, stall,
        output BrUn, PCSel, pc_target, flush_if, flush_id, illegal_br,
        output br_total_cnt, br_taken_cnt
    );
`else
    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, funct3, BrEq, BrLT, target, stall,
        input  BrUn, PCSel, pc_target, flush_if, flush_id, illegal_br
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, funct3, BrEq, BrLT, target, stall,
        output BrUn, PCSel, pc_target, flush_if, flush_id, illegal_br
    );
`endif

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition decode: taken flag, unsigned-compare select, reserved-code flag.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       BrEq_i,
    input  logic       BrLT_i,
    output logic       taken_o,
    output logic       BrUn_o,
    output logic       illegal_o
);

    assign BrUn_o = (funct3_i == F3_BLTU) || (funct3_i == F3_BGEU);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = BrEq_i;
            F3_BNE:  taken_o = !BrEq_i;
            F3_BLT:  taken_o = BrLT_i;
            F3_BGE:  taken_o = !BrLT_i;
            F3_BLTU: taken_o = BrLT_i;
            F3_BGEU: taken_o = !BrLT_i;
            default: illegal_o = 1'b1;  // 010 / 011 are reserved
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps into a registered fetch redirect plus a FLUSH_CYCLES-long
// IF/ID flush window. Define BRANCH_STATS_EN to add saturating branch statistics counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic           clk,
    input  logic           reset,
    branch_resolve_if.slave bus
);

    logic taken, illegal;

    branch_cond u_cond (
        .funct3_i  (bus.funct3),
        .BrEq_i    (bus.BrEq),
        .BrLT_i    (bus.BrLT),
        .taken_o   (taken),
        .BrUn_o    (bus.BrUn),
        .illegal_o (illegal)
    );

    br_state_e       state_q;
    logic [1:0]      cnt_q;
    logic            pcsel_q, flush_q, illegal_q;
    logic [XLEN-1:0] pc_target_q;

    logic idle_sample, resolve, br_eval;
    assign idle_sample = bus.ex_valid && !bus.stall && (state_q == ST_IDLE);
    assign resolve     = idle_sample && (bus.ex_is_jump || (bus.ex_is_branch && taken));
    assign br_eval     = idle_sample && bus.ex_is_branch && !bus.ex_is_jump;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pcsel_q     <= 1'b0;
            flush_q     <= 1'b0;
            illegal_q   <= 1'b0;
            pc_target_q <= '0;
        end else if (!bus.stall) begin
            case (state_q)
                ST_IDLE: begin
                    illegal_q <= br_eval && illegal;
                    if (resolve) begin
                        state_q     <= ST_REDIRECT;
                        pcsel_q     <= 1'b1;
                        flush_q     <= 1'b1;
                        pc_target_q <= bus.target;
                        cnt_q       <= '0;
                    end else begin
                        pcsel_q <= 1'b0;
                        flush_q <= 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    pcsel_q   <= 1'b0;
                    illegal_q <= 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        // The redirect cycle already counts as flush cycle 0
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                        cnt_q   <= 2'd1;
                    end
                end
                ST_FLUSH: begin
                    illegal_q <= 1'b0;
                    if (cnt_q == 2'(FLUSH_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pcsel_q <= 1'b0;
                    flush_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.PCSel      = pcsel_q;
    assign bus.pc_target  = pc_target_q;
    assign bus.flush_if   = flush_q;
    assign bus.flush_id   = flush_q;
    assign bus.illegal_br = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] total_q, total_d, taken_cnt_q, taken_cnt_d;

    // Reserved funct3 codes are not valid branches, so they are not counted
    always_comb begin
        total_d     = total_q;
        taken_cnt_d = taken_cnt_q;
        if (br_eval && !illegal) begin
            if (total_q != '1) total_d = total_q + 32'd1;
            if (taken && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            total_q     <= total_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.br_total_cnt = total_q;
    assign bus.br_taken_cnt = taken_cnt_q;
`else
    logic unused_br_eval;
    assign unused_br_eval = br_eval;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-level expectation model and literal spot checks.
module tb_branch_resolve;

    localparam int FC   = 2;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(XLEN)) bus ();

    branch_resolve #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outputs follow from how many flush cycles are still owed
    function automatic bit m_taken(input logic [2:0] f, input logic eq, input logic lt);
        case (f)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return lt;
            3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    int          m_rem;
    bit          m_pcsel, m_ill;
    logic [31:0] m_tgt;
    int unsigned m_total, m_takn;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem <= 0; m_pcsel <= 0; m_ill <= 0; m_tgt <= 0; m_total <= 0; m_takn <= 0;
        end else if (!bus.stall) begin
            if (m_rem == 0) begin
                if (bus.ex_valid && bus.ex_is_branch && !bus.ex_is_jump &&
                    !(bus.funct3 == 3'd2 || bus.funct3 == 3'd3)) begin
                    m_total <= m_total + 1;
                    if (m_taken(bus.funct3, bus.BrEq, bus.BrLT)) m_takn <= m_takn + 1;
                end
                if (bus.ex_valid && (bus.ex_is_jump ||
                    (bus.ex_is_branch && m_taken(bus.funct3, bus.BrEq, bus.BrLT)))) begin
                    m_rem <= FC; m_pcsel <= 1; m_tgt <= bus.target; m_ill <= 0;
                end else begin
                    m_pcsel <= 0;
                    m_ill   <= bus.ex_valid && bus.ex_is_branch && !bus.ex_is_jump &&
                               (bus.funct3 == 3'd2 || bus.funct3 == 3'd3);
                end
            end else begin
                m_rem <= m_rem - 1; m_pcsel <= 0; m_ill <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pcsel", bus.PCSel, m_pcsel);
            chk("pc_target", bus.pc_target, m_tgt);
            chk("flush_if", bus.flush_if, m_rem > 0);
            chk("flush_id", bus.flush_id, m_rem > 0);
            chk("illegal_br", bus.illegal_br, m_ill);
            chk("brun", bus.BrUn, bus.funct3 == 3'd6 || bus.funct3 == 3'd7);
`ifdef BRANCH_STATS_EN
            chk("br_total_cnt", bus.br_total_cnt, m_total);
            chk("br_taken_cnt", bus.br_taken_cnt, m_takn);
`endif
        end
    end

    task automatic drive(input bit v, input bit br, input bit jp, input logic [2:0] f3,
                         input bit eq, input bit lt, input logic [31:0] tgt, input bit st);
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jump = jp; bus.funct3 = f3;
        bus.BrEq = eq; bus.BrLT = lt; bus.target = tgt; bus.stall = st;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'd0, 0, 0, 32'h0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    typedef struct { logic [2:0] f3; bit eq; bit lt; bit jp; } vec_t;

    initial begin
        vec_t stv[6];
        idle();
        repeat (3) step();
        chk("rst_pcsel", bus.PCSel, 1'b0);
        chk("rst_target", bus.pc_target, 32'h0);
        chk("rst_flush", {bus.flush_if, bus.flush_id}, 2'b00);
        chk("rst_illegal", bus.illegal_br, 1'b0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // BEQ taken on the first edge after reset release
        drive(1, 1, 0, 3'b000, 1, 0, 32'h40, 0);
        step(); idle();
        chk("beq_pcsel", bus.PCSel, 1'b1);
        chk("beq_target", bus.pc_target, 32'h40);
        chk("beq_flush", {bus.flush_if, bus.flush_id}, 2'b11);
        step();
        chk("beq_f2_pcsel", bus.PCSel, 1'b0);
        chk("beq_f2_flush", {bus.flush_if, bus.flush_id}, 2'b11);
        step();
        chk("beq_done_flush", {bus.flush_if, bus.flush_id}, 2'b00);

        // BrUn decode, BGEU not taken, BLTU taken
        drive(0, 0, 0, 3'b110, 0, 0, 32'h0, 0); #1 chk("brun_110", bus.BrUn, 1'b1);
        drive(0, 0, 0, 3'b111, 0, 0, 32'h0, 0); #1 chk("brun_111", bus.BrUn, 1'b1);
        drive(0, 0, 0, 3'b100, 0, 0, 32'h0, 0); #1 chk("brun_100", bus.BrUn, 1'b0);
        drive(1, 1, 0, 3'b111, 0, 1, 32'h80, 0);
        step(); idle();
        chk("bgeu_nt_pcsel", bus.PCSel, 1'b0);
        chk("bgeu_nt_flush", bus.flush_if, 1'b0);
        drive(1, 1, 0, 3'b110, 0, 1, 32'h90, 0);
        step(); idle();
        chk("bltu_pcsel", bus.PCSel, 1'b1);
        chk("bltu_target", bus.pc_target, 32'h90);
        repeat (FC) step();

        // Jump beats a failing condition; branches during the bubble are dropped
        drive(1, 0, 1, 3'b001, 1, 0, 32'h100, 0);
        step();
        chk("jmp_pcsel", bus.PCSel, 1'b1);
        chk("jmp_target", bus.pc_target, 32'h100);
        drive(1, 1, 0, 3'b000, 1, 0, 32'h200, 0);
        step();
        chk("bubble_pcsel", bus.PCSel, 1'b0);
        chk("bubble_target", bus.pc_target, 32'h100);
        idle();
        step();
        chk("bubble_end_flush", bus.flush_if, 1'b0);
        chk("bubble_end_pcsel", bus.PCSel, 1'b0);

        // Stall held over REDIRECT keeps PCSel up for 4 cycles
        drive(1, 1, 0, 3'b101, 0, 0, 32'h300, 0);
        step();
        drive(0, 0, 0, 3'b000, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pcsel", bus.PCSel, 1'b1);
            chk("stall_target", bus.pc_target, 32'h300);
        end
        idle();
        step();
        chk("post_stall_pcsel", bus.PCSel, 1'b0);
        chk("post_stall_flush", bus.flush_id, 1'b1);
        step();
        chk("post_stall_idle", bus.flush_id, 1'b0);

        // Stall blocks sampling in IDLE
        drive(1, 1, 0, 3'b001, 0, 0, 32'h350, 1);
        step();
        chk("stall_idle_pcsel", bus.PCSel, 1'b0);
        bus.stall = 1'b0;
        step(); idle();
        chk("unstall_pcsel", bus.PCSel, 1'b1);
        chk("unstall_target", bus.pc_target, 32'h350);
        repeat (FC) step();

        // Async reset in FLUSH, then a reserved funct3
        drive(1, 1, 0, 3'b100, 0, 1, 32'h400, 0);
        step(); idle();
        step();
        chk("pre_rst_flush", bus.flush_if, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_flush", {bus.flush_if, bus.flush_id}, 2'b00);
        chk("midrst_pcsel", bus.PCSel, 1'b0);
        chk("midrst_target", bus.pc_target, 32'h0);
        step();
        reset = 1'b1;
        drive(1, 1, 0, 3'b011, 1, 1, 32'h500, 0);
        step(); idle();
        chk("ill_pulse", bus.illegal_br, 1'b1);
        chk("ill_pcsel", bus.PCSel, 1'b0);
        step();
        chk("ill_clear", bus.illegal_br, 1'b0);

        // 5 branches (3 taken) plus 1 jump, fresh from reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        stv[0] = '{3'b000, 1, 0, 0};
        stv[1] = '{3'b001, 1, 0, 0};
        stv[2] = '{3'b100, 0, 1, 0};
        stv[3] = '{3'b101, 0, 1, 0};
        stv[4] = '{3'b111, 0, 0, 0};
        stv[5] = '{3'b000, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            drive(1, !stv[i].jp, stv[i].jp, stv[i].f3, stv[i].eq, stv[i].lt, 32'h600 + 32'(i * 4), 0);
            step(); idle();
            repeat (FC) step();
        end
`ifdef BRANCH_STATS_EN
        chk("stats_total", bus.br_total_cnt, 32'd5);
        chk("stats_taken", bus.br_taken_cnt, 32'd3);
`endif
        chk("stats_last_target", bus.pc_target, 32'h614);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
